// File: rtl/cache_control_if.sv
// CPU / physical-memory / datapath-control signal bundle for cache_control.
// slave is the controller side; master is the side driving requests and responses.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic hit;
  logic dirty;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic load_data;
  logic load_tag;
  logic load_valid;
  logic load_dirty;
  logic dirty_in;
  logic data_sel;
  logic addr_sel;

  modport slave (
    input  mem_read, mem_write, hit, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, load_data, load_tag,
           load_valid, load_dirty, dirty_in, data_sel, addr_sel
  );

  modport master (
    output mem_read, mem_write, hit, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, load_data, load_tag,
           load_valid, load_dirty, dirty_in, data_sel, addr_sel
  );
endinterface

// File: rtl/cache_control.sv
// Write-back cache controller FSM (IDLE / WRITEBACK / ALLOCATE).
// Optional saturating hit/miss counters under `define CACHE_CONTROL_PERF_CNT_EN.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_if.slave       bus
`ifdef CACHE_CONTROL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic req;
  logic mem_resp_d, pmem_read_d, pmem_write_d;
  logic load_data_d, load_tag_d, load_valid_d, load_dirty_d;
  logic dirty_in_d, data_sel_d, addr_sel_d;

  // A simultaneous read+write is a write, so mem_write alone selects the write path.
  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_resp_d   = 1'b0;
    pmem_read_d  = 1'b0;
    pmem_write_d = 1'b0;
    load_data_d  = 1'b0;
    load_tag_d   = 1'b0;
    load_valid_d = 1'b0;
    load_dirty_d = 1'b0;
    dirty_in_d   = 1'b0;
    data_sel_d   = 1'b0;
    addr_sel_d   = 1'b0;
    // Outputs are gated by rst_n so strobes drop asynchronously, even mid-transaction.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (bus.hit) begin
              mem_resp_d = 1'b1;
              if (bus.mem_write) begin
                load_data_d  = 1'b1;
                load_dirty_d = 1'b1;
                dirty_in_d   = 1'b1;
              end
            end else begin
              state_d = bus.dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write_d = 1'b1;
          addr_sel_d   = 1'b1;
          if (bus.pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read_d = 1'b1;
          if (bus.pmem_resp) begin
            load_data_d  = 1'b1;
            data_sel_d   = 1'b1;
            load_tag_d   = 1'b1;
            load_valid_d = 1'b1;
            load_dirty_d = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.mem_resp   = mem_resp_d;
  assign bus.pmem_read  = pmem_read_d;
  assign bus.pmem_write = pmem_write_d;
  assign bus.load_data  = load_data_d;
  assign bus.load_tag   = load_tag_d;
  assign bus.load_valid = load_valid_d;
  assign bus.load_dirty = load_dirty_d;
  assign bus.dirty_in   = dirty_in_d;
  assign bus.data_sel   = data_sel_d;
  assign bus.addr_sel   = addr_sel_d;

`ifdef CACHE_CONTROL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Each IDLE request cycle is classified once; a retry hit after allocate counts as a hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && req) begin
      if (bus.hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else         miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed-vector bench for cache_control; output vector order:
// {mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid, load_dirty, dirty_in, data_sel, addr_sel}
module tb_cache_control;
`ifdef CACHE_CONTROL_PERF_CNT_EN
  localparam int CW = 2;
  logic [CW-1:0] hit_count, miss_count;
`else
  localparam int CW = 16;
`endif

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  cache_control_if bus ();

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_CONTROL_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_data,
                 bus.load_tag, bus.load_valid, bus.load_dirty, bus.dirty_in,
                 bus.data_sel, bus.addr_sel};

  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_RDHIT = 10'b1000000000;
  localparam logic [9:0] O_WRHIT = 10'b1001001100;
  localparam logic [9:0] O_WB    = 10'b0010000001;
  localparam logic [9:0] O_ALLOC = 10'b0100000000;
  localparam logic [9:0] O_FILL  = 10'b0101111010;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply inputs after the falling edge, then check the combinational outputs.
  task automatic step(input string tag, input logic rd, input logic wr, input logic h,
                      input logic d, input logic pr, input logic [9:0] exp);
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit       = h;
    bus.dirty     = d;
    bus.pmem_resp = pr;
    #1;
    chk(tag, {22'd0, outs}, {22'd0, exp});
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b1;
    bus.dirty     = 1'b0;
    bus.pmem_resp = 1'b0;
    #2;
    chk("reset_outs", {22'd0, outs}, {22'd0, O_NONE});
    @(posedge clk); #1;
    chk("reset_outs_edge", {22'd0, outs}, {22'd0, O_NONE});
`ifdef CACHE_CONTROL_PERF_CNT_EN
    chk("reset_hitcnt", 32'(hit_count), 32'd0);
    chk("reset_misscnt", 32'(miss_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_read = 1'b0;
    bus.hit      = 1'b0;

    step("idle_noreq", 0, 0, 0, 0, 0, O_NONE);
    step("read_hit",   1, 0, 1, 0, 0, O_RDHIT);
    step("write_hit",  0, 1, 1, 1, 0, O_WRHIT);
    step("rdwr_hit",   1, 1, 1, 0, 0, O_WRHIT);

    // Clean read miss, pmem responds on the third ALLOCATE cycle.
    step("clean_idle",   1, 0, 0, 0, 0, O_NONE);
    step("clean_alloc1", 1, 0, 0, 0, 0, O_ALLOC);
    step("clean_alloc2", 1, 0, 0, 0, 0, O_ALLOC);
    step("clean_fill",   1, 0, 0, 0, 1, O_FILL);
    step("clean_retry",  1, 0, 1, 0, 0, O_RDHIT);

    // Dirty write miss: writeback, allocate, then write hit.
    step("dirty_idle",  0, 1, 0, 1, 0, O_NONE);
    step("dirty_wb1",   0, 1, 0, 1, 0, O_WB);
    step("dirty_wb2",   0, 1, 0, 1, 1, O_WB);
    step("dirty_alloc", 0, 1, 0, 1, 0, O_ALLOC);
    step("dirty_fill",  0, 1, 0, 1, 1, O_FILL);
    step("dirty_retry", 0, 1, 1, 0, 0, O_WRHIT);

    // Request withdrawn during ALLOCATE: fill completes, no response afterwards.
    step("wd_idle",  1, 0, 0, 0, 0, O_NONE);
    step("wd_alloc", 0, 0, 0, 0, 0, O_ALLOC);
    step("wd_fill",  0, 0, 0, 0, 1, O_FILL);
    step("wd_after", 0, 0, 1, 0, 0, O_NONE);

    // Asynchronous reset in the middle of ALLOCATE.
    step("rst_idle",  1, 0, 0, 0, 0, O_NONE);
    step("rst_alloc", 1, 0, 0, 0, 0, O_ALLOC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", {22'd0, outs}, {22'd0, O_NONE});
    bus.hit = 1'b1;
    #1;
    chk("rst_no_resp", {22'd0, outs}, {22'd0, O_NONE});
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_read = 1'b0;
    bus.hit      = 1'b0;
#1;
`ifdef CACHE_CONTROL_PERF_CNT_EN
    chk("cnt_clear_hit", 32'(hit_count), 32'd0);
    chk("cnt_clear_miss", 32'(miss_count), 32'd0);
`endif
    step("post_rst_hit", 1, 0, 1, 0, 0, O_RDHIT);

`ifdef CACHE_CONTROL_PERF_CNT_EN
    step("cnt_miss_idle", 1, 0, 0, 0, 0, O_NONE);
    step("cnt_alloc",     1, 0, 0, 0, 0, O_ALLOC);
    chk("cnt_miss1", 32'(miss_count), 32'd1);
    chk("cnt_hit_hold", 32'(hit_count), 32'd1);
    step("cnt_fill",      1, 0, 0, 0, 1, O_FILL);
    step("cnt_retry",     1, 0, 1, 0, 0, O_RDHIT);
    chk("cnt_hit_hold2", 32'(hit_count), 32'd1);
    for (int i = 0; i < 3; i++) step("cnt_hit_more", 1, 0, 1, 0, 0, O_RDHIT);
    step("cnt_drop", 0, 0, 0, 0, 0, O_NONE);
    chk("cnt_hit_sat", 32'(hit_count), 32'd3);
    chk("cnt_miss_final", 32'(miss_count), 32'd1);
`endif

    step("final_idle", 0, 0, 0, 0, 0, O_NONE);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
